// File: rtl/readout_seq_pkg.sv
// rtl/readout_seq_pkg.sv - shared state encoding, width defaults and row-length helper
package readout_seq_pkg;

   localparam int ROW_W_DEF = 10;
   localparam int FRM_W_DEF = 16;

   typedef enum logic [4:0] {
      RO_idle   = 5'b00001,
      RO_settle = 5'b00010,
      RO_row    = 5'b00100,
      RO_stall  = 5'b01000,
      RO_done   = 5'b10000
   } ro_state_t;

   // A row needs at least one strobe cycle plus the row_done cycle.
   function automatic logic [31:0] eff_row_len(input logic [31:0] t_row);
      return (t_row < 32'd2) ? 32'd2 : t_row;
   endfunction

endpackage

// File: rtl/ro_window_dec.sv
// rtl/ro_window_dec.sv - combinational start/width window compare on the row cycle counter
module ro_window_dec (
   input  logic [31:0] cnt,
   input  logic [31:0] start,
   input  logic [31:0] width,
   output logic        hit
);

   logic [32:0] stop;

   // The end is kept in 33 bits so a window near 2^32 never wraps back to row cycle 0.
   assign stop = {1'b0, start} + {1'b0, width};
   assign hit  = (cnt >= start) && ({1'b0, cnt} < stop);

endmodule

// File: rtl/readout_seq.sv
// rtl/readout_seq.sv - trigger/busy readout sequencer scanning pixel rows with per-row strobes
module readout_seq
   import readout_seq_pkg::*;
#(
   parameter int ROW_W = ROW_W_DEF,
   parameter int FRM_W = FRM_W_DEF
) (
   input  logic             CLKM,
   input  logic             rst,
   input  logic             trigger_i,
   output logic             re_busy,
   input  logic [ROW_W-1:0] NUM_ROW,
   input  logic [31:0]      T_settle,
   input  logic [31:0]      T_row,
   input  logic [31:0]      T_rs,
   input  logic [31:0]      T_rw,
   input  logic [31:0]      T_shr,
   input  logic [31:0]      T_shs,
   input  logic [31:0]      T_sw,
   input  logic [31:0]      T_adc,
   input  logic             fifo_full,
   output logic [ROW_W-1:0] ROWADD,
   output logic             ROWSEL,
   output logic             PIXRES,
   output logic             SH_RST,
   output logic             SH_SIG,
   output logic             ADC_START,
   output logic             row_done,
   output logic [FRM_W-1:0] frame_cnt
);

   localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);
   localparam logic [FRM_W-1:0] FRM_ONE = FRM_W'(1);

   ro_state_t        state, state_nxt;
   logic [31:0]      cnt_t, cnt_nxt;
   logic [ROW_W-1:0] row, row_nxt;
   logic [ROW_W-1:0] num_lat, num_lat_nxt;
   logic [FRM_W-1:0] frame_q, frame_nxt;
   logic [31:0]      row_last;
   logic             in_row;
   logic             settle_end;
   logic             row_end;
   logic             last_row;
   logic             pix_hit;
   logic             shr_hit;
   logic             shs_hit;

   assign row_last   = eff_row_len(T_row) - 32'd1;
   assign in_row     = (state == RO_row);
   assign settle_end = ({1'b0, cnt_t} + 33'd1) >= {1'b0, T_settle};
   assign row_end    = in_row && (cnt_t >= row_last);
   assign last_row   = (row == num_lat - ROW_ONE);

   always_ff @(posedge CLKM) begin
      if (rst) begin
         state   <= RO_idle;
         cnt_t   <= '0;
         row     <= '0;
         num_lat <= '0;
         frame_q <= '0;
      end else begin
         state   <= state_nxt;
         cnt_t   <= cnt_nxt;
         row     <= row_nxt;
         num_lat <= num_lat_nxt;
         frame_q <= frame_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt_t;
      row_nxt     = row;
      num_lat_nxt = num_lat;
      frame_nxt   = frame_q;
      re_busy     = 1'b0;
      case (state)
         RO_idle: begin
            if (trigger_i) begin
               state_nxt   = RO_settle;
               num_lat_nxt = NUM_ROW;
               cnt_nxt     = '0;
            end
         end
         RO_settle: begin
            re_busy = 1'b1;
            if (settle_end) begin
               cnt_nxt = '0;
               row_nxt = '0;
               if (num_lat == '0) begin
                  state_nxt = RO_done;
                  frame_nxt = frame_q + FRM_ONE;
               end else begin
                  state_nxt = RO_row;
               end
            end else begin
               cnt_nxt = cnt_t + 32'd1;
            end
         end
         RO_row: begin
            re_busy = 1'b1;
            if (row_end) begin
               // The last row finishes the frame even if the buffer reports full.
               if (last_row) begin
                  state_nxt = RO_done;
                  frame_nxt = frame_q + FRM_ONE;
               end else if (fifo_full) begin
                  state_nxt = RO_stall;
               end else begin
                  row_nxt = row + ROW_ONE;
                  cnt_nxt = '0;
               end
            end else begin
               cnt_nxt = cnt_t + 32'd1;
            end
         end
         RO_stall: begin
            re_busy = 1'b1;
            if (!fifo_full) begin
               state_nxt = RO_row;
               row_nxt   = row + ROW_ONE;
               cnt_nxt   = '0;
            end
         end
         RO_done: begin
            // Re-arm guard: a trigger still held from this frame must drop first.
            if (!trigger_i) begin
               state_nxt = RO_idle;
            end
         end
         default: begin
            state_nxt = RO_idle;
         end
      endcase
   end

   ro_window_dec u_pix (.cnt(cnt_t), .start(T_rs),  .width(T_rw), .hit(pix_hit));
   ro_window_dec u_shr (.cnt(cnt_t), .start(T_shr), .width(T_sw), .hit(shr_hit));
   ro_window_dec u_shs (.cnt(cnt_t), .start(T_shs), .width(T_sw), .hit(shs_hit));

   // Strobes are registered decodes, so they trail cnt_t by one cycle.
   always_ff @(posedge CLKM) begin
      if (rst) begin
         ROWSEL    <= 1'b0;
         PIXRES    <= 1'b0;
         SH_RST    <= 1'b0;
         SH_SIG    <= 1'b0;
         ADC_START <= 1'b0;
         row_done  <= 1'b0;
      end else begin
         ROWSEL    <= in_row && (cnt_t < row_last);
         PIXRES    <= in_row && pix_hit;
         SH_RST    <= in_row && shr_hit;
         SH_SIG    <= in_row && shs_hit;
         ADC_START <= in_row && (cnt_t == T_adc);
         row_done  <= row_end;
      end
   end

   assign ROWADD    = row;
   assign frame_cnt = frame_q;

endmodule
